// File: rtl/puzzle_loader.sv
// puzzle_loader
//   Picks a puzzle for the requested difficulty and streams it out of the
//   synchronous puzzle ROM one row per read. It assembles the full value map
//   and visibility map for the game state machine, and flags bad ROM content.
//
// Ports
//   clk                 system clock
//   reset               asynchronous, active-high reset
//   load_req            one-cycle request to load a new puzzle (ignored while busy)
//   difficulty          0 = easy, 1 = hard; latched on an accepted request
//   abort               cancel a load that is in FETCH or CAPTURE
//   rom_en              ROM read strobe (high only in FETCH)
//   rom_addr            {difficulty, puzzle_idx, row[3:0]}; 0 outside FETCH
//   rom_board_row       nine 4-bit cells, valid the cycle after rom_en
//   rom_vis_row         nine 2-bit visibility codes, valid with rom_board_row
//   selected_map        assembled board, cell (i,j) at [(i*9+j)*4 +: 4]
//   selected_visibility assembled visibility, cell (i,j) at [(i*9+j)*2 +: 2]
//   puzzle_id           index of the last puzzle that completed loading
//   busy                high in FETCH, CAPTURE and DONE
//   done                one-cycle pulse when a load completes
//   rom_error           sticky: a board nibble was 0 or above 9
module puzzle_loader #(
    parameter int unsigned PUZZLE_BITS = 3,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_req,
    input  logic                     difficulty,
    input  logic                     abort,
    output logic                     rom_en,
    output logic [PUZZLE_BITS+4:0]   rom_addr,
    input  logic [35:0]              rom_board_row,
    input  logic [17:0]              rom_vis_row,
    output logic [323:0]             selected_map,
    output logic [161:0]             selected_visibility,
    output logic [PUZZLE_BITS-1:0]   puzzle_id,
    output logic                     busy,
    output logic                     done,
    output logic                     rom_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                 state;
    logic [7:0]             lfsr;
    logic                   lfsr_fb;
    logic [3:0]             row;
    logic                   diff_q;
    logic [PUZZLE_BITS-1:0] idx_q;
    logic                   last_valid;
    logic [PUZZLE_BITS-1:0] candidate;
    logic [PUZZLE_BITS-1:0] chosen;
    logic                   row_bad;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting toward the MSB.
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Never hand out the same puzzle twice in a row.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        candidate = lfsr[PUZZLE_BITS-1:0];
        chosen    = candidate;
        if (last_valid && (candidate == puzzle_id))
            chosen = candidate + PUZZLE_BITS'(1);
    end

    // A legal cell value is 1..9; anything else in the incoming row is a content fault.
    always_comb begin
        row_bad = 1'b0;
        for (int j = 0; j < 9; j++) begin
            if ((rom_board_row[j*4 +: 4] == 4'd0) || (rom_board_row[j*4 +: 4] > 4'd9))
                row_bad = 1'b1;
        end
    end

    // NOTE: state and outputs are registered with non-blocking assignments so every
    // read in this block sees the pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the wide map registers are reset too; downstream checks the board
            // for nonzero content and must never see power-up garbage.
            state               <= S_IDLE;
            lfsr                <= LFSR_SEED;
            row                 <= 4'd0;
            diff_q              <= 1'b0;
            idx_q               <= '0;
            last_valid          <= 1'b0;
            puzzle_id           <= '0;
            selected_map        <= '0;
            selected_visibility <= '0;
            rom_en              <= 1'b0;
            rom_addr            <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            rom_error           <= 1'b0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
            done <= 1'b0;

            if (abort && ((state == S_FETCH) || (state == S_CAPTURE))) begin
                state               <= S_IDLE;
                rom_en              <= 1'b0;
                rom_addr            <= '0;
                busy                <= 1'b0;
                selected_map        <= '0;
                selected_visibility <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (load_req) begin
                            diff_q              <= difficulty;
                            idx_q               <= chosen;
                            row                 <= 4'd0;
                            selected_map        <= '0;
                            selected_visibility <= '0;
                            rom_error           <= 1'b0;
                            rom_en              <= 1'b1;
                            rom_addr            <= {difficulty, chosen, 4'd0};
                            busy                <= 1'b1;
                            state               <= S_FETCH;
                        end
                    end

                    S_FETCH: begin
                        rom_en   <= 1'b0;
                        rom_addr <= '0;
                        state    <= S_CAPTURE;
                    end

                    S_CAPTURE: begin
                        // Constant-index slices keep the writes inside the 9 real rows.
                        for (int i = 0; i < 9; i++) begin
                            if (row == 4'(i)) begin
                                selected_map[i*36 +: 36]        <= rom_board_row;
                                selected_visibility[i*18 +: 18] <= rom_vis_row;
                            end
                        end
                        if (row_bad)
                            rom_error <= 1'b1;
                        if (row == 4'd8) begin
                            done       <= 1'b1;
                            puzzle_id  <= idx_q;
                            last_valid <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            row      <= row + 4'd1;
                            rom_en   <= 1'b1;
                            rom_addr <= {diff_q, idx_q, row + 4'd1};
                            state    <= S_FETCH;
                        end
                    end

                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_puzzle_loader.sv
// tb_puzzle_loader
//   Directed and randomized loads against a ROM model and a reference model of
//   the puzzle-selection rules, covering reset, basic load, address/difficulty
//   latching, no-repeat, content faults, abort and reset mid-load.
module tb_puzzle_loader;

    localparam int PB = 3;
    localparam int NA = 1 << (PB + 5);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_req = 1'b0;
    logic          difficulty = 1'b0;
    logic          abort = 1'b0;
    logic          rom_en;
    logic [PB+4:0] rom_addr;
    logic [35:0]   rom_board_row = '0;
    logic [17:0]   rom_vis_row = '0;
    logic [323:0]  selected_map;
    logic [161:0]  selected_visibility;
    logic [PB-1:0] puzzle_id;
    logic          busy;
    logic          done;
    logic          rom_error;

    int checks = 0;
    int errors = 0;

    logic [35:0]   rom_board [NA];
    logic [17:0]   rom_vis   [NA];

    logic [7:0]    ref_lfsr;
    logic [PB-1:0] ref_pid = '0;
    bit            ref_last_valid = 1'b0;

    puzzle_loader #(.PUZZLE_BITS(PB), .LFSR_SEED(8'hA5)) dut (
        .clk                 (clk),
        .reset               (reset),
        .load_req            (load_req),
        .difficulty          (difficulty),
        .abort               (abort),
        .rom_en              (rom_en),
        .rom_addr            (rom_addr),
        .rom_board_row       (rom_board_row),
        .rom_vis_row         (rom_vis_row),
        .selected_map        (selected_map),
        .selected_visibility (selected_visibility),
        .puzzle_id           (puzzle_id),
        .busy                (busy),
        .done                (done),
        .rom_error           (rom_error)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clk) begin
        if (rom_en) begin
            rom_board_row <= rom_board[rom_addr];
            rom_vis_row   <= rom_vis[rom_addr];
        end
    end

    // Selector sequence: parity of the tapped bits (8,6,5,4) shifted in each cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) ref_lfsr <= 8'hA5;
        else       ref_lfsr <= {ref_lfsr[6:0], ^(ref_lfsr & 8'hB8)};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [323:0] obs, input logic [323:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit row_has_fault(input logic [35:0] v);
        logic [3:0] nib;
        for (int j = 0; j < 9; j++) begin
            nib = v[j*4 +: 4];
            if (nib < 4'd1 || nib > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    // mode 0: row r of every puzzle holds nibble r+1, all cells visible.
    // mode 1: random legal nibbles, random visibility codes.
    task automatic fill_rom(input int mode);
        for (int a = 0; a < NA; a++) begin
            for (int j = 0; j < 9; j++)
                rom_board[a][j*4 +: 4] = (mode == 0) ? 4'((a % 16) + 1) : 4'($urandom_range(1, 9));
            rom_vis[a] = (mode == 0) ? '1 : 18'($urandom);
        end
    endtask

    task automatic wait_cand(input logic [PB-1:0] target);
        int n = 0;
        while (ref_lfsr[PB-1:0] != target && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $error("FAIL wait_cand: candidate %0d never appeared", target);
        end
    endtask

    // Issues load_req in the current cycle and checks every cycle of the load.
    // abort_cyc = 0 means no abort; spam re-requests during cycles 1..5.
    task automatic run_load(input bit diff, input bit toggle, input int abort_cyc, input bit spam);
        logic [PB-1:0] cand;
        logic [PB-1:0] idx;
        logic [PB+4:0] a;
        logic [323:0]  emap, pmap;
        logic [161:0]  evis, pvis;
        logic          eerr, perr;
        int            written;

        cand = ref_lfsr[PB-1:0];
        idx  = (ref_last_valid && cand == ref_pid) ? PB'(cand + 1) : cand;
        emap = '0;
        evis = '0;
        eerr = 1'b0;
        for (int r = 0; r < 9; r++) begin
            a = {diff, idx, 4'(r)};
            emap[r*36 +: 36] = rom_board[a];
            evis[r*18 +: 18] = rom_vis[a];
            eerr |= row_has_fault(rom_board[a]);
        end

        load_req = 1'b1;
        difficulty = diff;
        step();
        load_req = 1'b0;
        abort = 1'b0;

        for (int c = 1; c <= 19; c++) begin
            written = (c - 1) / 2;
            pmap = '0;
            pvis = '0;
            perr = 1'b0;
            for (int r = 0; r < written; r++) begin
                pmap[r*36 +: 36] = emap[r*36 +: 36];
                pvis[r*18 +: 18] = evis[r*18 +: 18];
                a = {diff, idx, 4'(r)};
                perr |= row_has_fault(rom_board[a]);
            end
            chk($sformatf("c%0d busy", c), 324'(busy), 324'(1'b1));
            chk($sformatf("c%0d done", c), 324'(done), 324'(c == 19));
            chk($sformatf("c%0d rom_en", c), 324'(rom_en), 324'(c % 2 == 1 && c < 19));
            if (c % 2 == 1 && c < 19)
                chk($sformatf("c%0d rom_addr", c), 324'(rom_addr), 324'({diff, idx, 4'((c - 1) / 2)}));
            else
                chk($sformatf("c%0d rom_addr", c), 324'(rom_addr), 324'(0));
            chk($sformatf("c%0d map", c), selected_map, pmap);
            chk($sformatf("c%0d vis", c), 324'(selected_visibility), 324'(pvis));
            chk($sformatf("c%0d rom_error", c), 324'(rom_error), 324'(perr));

            if (c == abort_cyc) begin
                load_req = 1'b0;
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk("abort busy", 324'(busy), 324'(0));
                chk("abort rom_en", 324'(rom_en), 324'(0));
                chk("abort rom_addr", 324'(rom_addr), 324'(0));
                chk("abort done", 324'(done), 324'(0));
                chk("abort map", selected_map, 324'(0));
                chk("abort vis", 324'(selected_visibility), 324'(0));
                chk("abort puzzle_id", 324'(puzzle_id), 324'(ref_pid));
                repeat (3) begin
                    step();
                    chk("post-abort done", 324'(done), 324'(0));
                    chk("post-abort busy", 324'(busy), 324'(0));
                end
                return;
            end

            if (toggle) difficulty = ~difficulty;
            load_req = spam && (c <= 5);
            step();
        end

        load_req = 1'b0;
        chk("end busy", 324'(busy), 324'(0));
        chk("end done", 324'(done), 324'(0));
        chk("end puzzle_id", 324'(puzzle_id), 324'(idx));
        chk("end map", selected_map, emap);
        chk("end vis", 324'(selected_visibility), 324'(evis));
        chk("end rom_error", 324'(rom_error), 324'(eerr));
        ref_pid = idx;
        ref_last_valid = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " rom_en"}, 324'(rom_en), 324'(0));
        chk({tag, " rom_addr"}, 324'(rom_addr), 324'(0));
        chk({tag, " map"}, selected_map, 324'(0));
        chk({tag, " vis"}, 324'(selected_visibility), 324'(0));
        chk({tag, " puzzle_id"}, 324'(puzzle_id), 324'(0));
        chk({tag, " busy"}, 324'(busy), 324'(0));
        chk({tag, " done"}, 324'(done), 324'(0));
        chk({tag, " rom_error"}, 324'(rom_error), 324'(0));
    endtask

    initial begin
        logic [PB-1:0] prev;
        bit            rdiff, rtog, rspam;
        int            acyc;

        fill_rom(0);

        // Reset
        #2 reset = 1'b1;
        repeat (2) step();
        check_reset_values("reset");
        reset = 1'b0;

        // Basic load
        run_load(1'b0, 1'b0, 0, 1'b0);
        chk("basic vis all ones", 324'(selected_visibility), 324'({162{1'b1}}));
        chk("basic row0", 324'(selected_map[35:0]), 324'({9{4'd1}}));
        chk("basic row8", 324'(selected_map[323:288]), 324'({9{4'd9}}));

        // Address / difficulty latching, difficulty toggled mid-load
        fill_rom(1);
        run_load(1'b1, 1'b1, 0, 1'b0);

        // No-repeat: request exactly when the candidate equals the last id
        prev = puzzle_id;
        wait_cand(ref_pid);
        run_load(1'b0, 1'b0, 0, 1'b0);
        chk("no-repeat +1", 324'(puzzle_id), 324'(PB'(prev + 1)));

        // No-repeat wrap: get puzzle 7 loaded, then hit candidate 7 again
        for (int k = 0; k < 4 && ref_pid != 3'd7; k++) begin
            wait_cand(3'd7);
            run_load(1'b1, 1'b0, 0, 1'b0);
        end
        wait_cand(3'd7);
        run_load(1'b0, 1'b0, 0, 1'b0);
        chk("no-repeat wrap", 324'(puzzle_id), 324'(0));

        // Content fault in row 5, cell 3 of every easy puzzle
        fill_rom(1);
        for (int i = 0; i < (1 << PB); i++)
            rom_board[{1'b0, PB'(i), 4'd5}][12 +: 4] = 4'hA;
        run_load(1'b0, 1'b0, 0, 1'b0);
        chk("fault rom_error", 324'(rom_error), 324'(1));
        repeat (3) step();
        chk("fault sticky", 324'(rom_error), 324'(1));
        fill_rom(1);
        run_load(1'b0, 1'b0, 0, 1'b0);

        // Abort in cycle 6 with ignored requests in cycles 1..5
        run_load(1'b0, 1'b0, 6, 1'b1);

        // load_req together with abort in IDLE is accepted
        abort = 1'b1;
        run_load(1'b1, 1'b0, 0, 1'b0);

        // Randomized loads
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 4)) step();
            rdiff = 1'($urandom_range(0, 1));
            rtog  = 1'($urandom_range(0, 1));
            rspam = 1'($urandom_range(0, 1));
            acyc  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 18)) : 0;
            if (n % 3 == 0) fill_rom(1);
            run_load(rdiff, rtog, acyc, rspam);
        end

        // Reset mid-load in cycle 9
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        repeat (8) step();
        reset = 1'b1;
        #1;
        check_reset_values("mid-reset");
        step();
        reset = 1'b0;
        ref_pid = '0;
        ref_last_valid = 1'b0;
        run_load(1'b0, 1'b0, 0, 1'b0);
        chk("post-reset seed id", 324'(puzzle_id), 324'(5));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/puzzle_loader.md
# puzzle_loader

Sequences a new game into the board datapath during the loading phase. On a load request it picks a puzzle for the chosen difficulty and reads it from the synchronous puzzle ROM, one row per read. It then assembles the full 324-bit value map and the 162-bit visibility map that the game state machine consumes as `selected_map` / `selected_visibility`. It also reports completion and any ROM content fault.

## Interface
- `PUZZLE_BITS`, default 3: puzzles per difficulty = 2^PUZZLE_BITS.
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `load_req`  in  1  one-cycle request to load a new puzzle.
- `difficulty`  in  1  0 = easy, 1 = hard; latched on an accepted request.
- `abort`  in  1  cancel an in-progress load.
- `rom_en`  out  1  ROM read strobe.
- `rom_addr`  out  PUZZLE_BITS+5  ROM address, {difficulty, puzzle_idx, row[3:0]}.
- `rom_board_row`  in  36  nine 4-bit cell values; cell j is at [j*4 +: 4]. Valid the cycle after `rom_en`.
- `rom_vis_row`  in  18  nine 2-bit visibility codes; cell j is at [j*2 +: 2]. A cell is visible iff both bits are 1.
- `selected_map`  out  324  assembled board; cell (i,j) is at [(i*9+j)*4 +: 4].
- `selected_visibility`  out  162  assembled visibility; cell (i,j) is at [(i*9+j)*2 +: 2].
- `puzzle_id`  out  PUZZLE_BITS  index of the last puzzle loaded.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when a load completes.
- `rom_error`  out  1  sticky content fault.

## Operation
- **Puzzle selector:** 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  - Advances every cycle, including during a load.
  - Candidate index = `lfsr[PUZZLE_BITS-1:0]`.
- **No-repeat rule:** if `last_valid` is set and the candidate equals `puzzle_id`, use candidate+1 modulo 2^PUZZLE_BITS.
- **IDLE:** `rom_en` = 0.
  - On `load_req`: latch `difficulty` and the chosen index.
  - Clear `selected_map`, `selected_visibility` and `rom_error` to 0.
  - Set row = 0 and go to FETCH.
- **FETCH:** `rom_en` = 1; `rom_addr` = {latched difficulty, latched index, row}. Next state is CAPTURE.
- **CAPTURE:** `rom_en` = 0.
  - Write `rom_board_row` to `selected_map[row*36 +: 36]`.
  - Write `rom_vis_row` to `selected_visibility[row*18 +: 18]`.
  - Any board nibble equal to 0 or greater than 9 sets `rom_error`.
  - If row == 8, go to DONE; otherwise row+1 and go to FETCH.
- **DONE:** `done` = 1; `puzzle_id` ← latched index; `last_valid` ← 1; next state is IDLE.
- `busy` = 1 in FETCH, CAPTURE and DONE.
- `abort` has priority over all other events and is honoured only in FETCH or CAPTURE.
  - Next state is IDLE; map and visibility are cleared to 0.
  - No `done` pulse; `puzzle_id` and `last_valid` are unchanged.
- `load_req` while busy is ignored; it is not queued.
- `rom_error` does not stop the load; `done` still pulses. It clears only on the next accepted `load_req` or on reset.
- `rom_addr` is 0 whenever not in FETCH.

## Timing
- **Reset values:** state IDLE, lfsr = `LFSR_SEED`, and all of the following are 0: row, `selected_map`, `selected_visibility`, `puzzle_id`, `last_valid`, `busy`, `done`, `rom_error`, `rom_en`, `rom_addr`.
- **ROM latency:** fixed at 1 cycle. Data is sampled at the clock edge that ends CAPTURE.
- **Load sequence**, with `load_req` sampled at edge 0:
  - FETCH in cycles 1, 3, …, 17.
  - CAPTURE in cycles 2, 4, …, 18.
  - `done` high in cycle 19; `busy` is 0 from cycle 20.
- Row r becomes visible on the outputs after the edge ending cycle 2r+2.
- Outputs are 0 from cycle 1 until the first row is written. The downstream "board nonzero" check therefore cannot pass on stale data.
- `load_req` and `abort` in the same IDLE cycle: the load is accepted, because `abort` is ignored in IDLE.
- `load_req` on the cycle immediately after DONE is accepted normally.
- **Asynchronous reset mid-load:** immediately returns everything to its reset values.

## Test plan
- **Basic load:** reset, then `load_req` with `difficulty` = 0 and the ROM model returning row r filled with nibble r+1, all vis bits 1.
  - `rom_en` pulses 9 times with row field 0..8.
  - `done` pulses once, at cycle 19.
  - `selected_map` row r is all (r+1); `selected_visibility` = all ones; `rom_error` = 0.
- **Address / difficulty:** `difficulty` = 1 at request, then toggled mid-load.
  - All 9 addresses carry MSB = 1 and a constant `puzzle_idx`.
  - Final `puzzle_id` equals that index.
- **No-repeat:** force two back-to-back loads where the LFSR yields the same candidate.
  - The second `puzzle_id` = first + 1 mod 8.
  - With index 7 the next is 0.
- **Fault:** ROM returns nibble 4'hA in row 5, cell 3.
  - Load completes with `done` pulse; `rom_error` = 1 and stays set.
  - The next accepted `load_req` clears it in cycle 1.
- **Abort:** assert `abort` in cycle 6 (CAPTURE of row 2).
  - Next cycle: IDLE, `busy` = 0, map and visibility 0, no `done`, `puzzle_id` unchanged.
  - `load_req` during cycles 1–5 had no effect.
- **Reset mid-load:** assert `reset` in cycle 9.
  - All outputs at reset values within the same cycle.
  - A subsequent load starts from LFSR = 8'hA5.
